// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with stall, branch/trap redirect
// and redirect buffering while the front end is held.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   i_hold       pipeline stall; freezes fetch and withholds the request
//   i_jump_en    branch/jump redirect request
//   i_jump_addr  branch/jump target
//   i_trap_en    exception/interrupt redirect request (beats jump)
//   i_trap_addr  trap vector target
//   i_is_c       current instruction is 16-bit (compressed builds only)
//   i_if_ready   fetch unit accepts the request this cycle
//   o_if_valid   fetch request valid (registered)
//   o_pc         fetch address (registered)
//
// Build option: define PC_GEN_RVC_EN for compressed-instruction support
// (2-byte increment when i_is_c, halfword-aligned redirect targets).
// Without it i_is_c is ignored and targets are word aligned.
module pc_gen #(
  parameter int unsigned            XLEN         = 32,
  parameter logic [XLEN-1:0]        RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_hold,
  input  logic            i_jump_en,
  input  logic [XLEN-1:0] i_jump_addr,
  input  logic            i_trap_en,
  input  logic [XLEN-1:0] i_trap_addr,
  input  logic            i_is_c,
  input  logic            i_if_ready,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

`ifdef PC_GEN_RVC_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(1);
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
`endif

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_if_valid;
  logic            r_pend_valid;
  logic            r_pend_trap;
  logic [XLEN-1:0] r_pend_addr;

  state_t          w_nxt_state;
  logic [XLEN-1:0] w_nxt_pc;
  logic            w_nxt_if_valid;
  logic            w_nxt_pend_valid;
  logic            w_nxt_pend_trap;
  logic [XLEN-1:0] w_nxt_pend_addr;

  logic            w_redir;
  logic [XLEN-1:0] w_redir_addr;
  logic            w_fire;
  logic [XLEN-1:0] w_inc;

  // Sequential step size
`ifdef PC_GEN_RVC_EN
  assign w_inc = i_is_c ? XLEN'(2) : XLEN'(4);
`else
  logic w_unused_is_c;
  assign w_unused_is_c = i_is_c;
  assign w_inc         = XLEN'(4);
`endif

  // Incoming redirect: trap beats jump, target aligned
  assign w_redir      = i_trap_en | i_jump_en;
  assign w_redir_addr = (i_trap_en ? i_trap_addr : i_jump_addr) & ALIGN_MASK;
  assign w_fire       = r_if_valid & i_if_ready;

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_VECTOR;
      r_if_valid   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_trap  <= 1'b0;
      r_pend_addr  <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_pc         <= w_nxt_pc;
      r_if_valid   <= w_nxt_if_valid;
      r_pend_valid <= w_nxt_pend_valid;
      r_pend_trap  <= w_nxt_pend_trap;
      r_pend_addr  <= w_nxt_pend_addr;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_pc         = r_pc;
    w_nxt_pend_valid = r_pend_valid;
    w_nxt_pend_trap  = r_pend_trap;
    w_nxt_pend_addr  = r_pend_addr;

    unique case (r_state)
      S_IDLE: begin
        w_nxt_pc         = RESET_VECTOR;
        w_nxt_state      = i_hold ? S_HOLD : S_RUN;
        w_nxt_pend_valid = 1'b0;
        w_nxt_pend_trap  = 1'b0;
        w_nxt_pend_addr  = '0;
      end

      S_RUN: begin
        // A redirect replaces the outstanding request even if it was not
        // accepted; an accepted request advances even as hold rises, so the
        // same address is never fetched twice.
        if (w_redir) begin
          w_nxt_pc = w_redir_addr;
        end else if (w_fire) begin
          w_nxt_pc = r_pc + w_inc;
        end
        w_nxt_state      = i_hold ? S_HOLD : S_RUN;
        w_nxt_pend_valid = 1'b0;
        w_nxt_pend_trap  = 1'b0;
        w_nxt_pend_addr  = '0;
      end

      S_HOLD: begin
        if (i_hold) begin
          // Buffer redirects; a pending trap is never displaced by a jump
          if (i_trap_en) begin
            w_nxt_pend_valid = 1'b1;
            w_nxt_pend_trap  = 1'b1;
            w_nxt_pend_addr  = w_redir_addr;
          end else if (i_jump_en && !(r_pend_valid && r_pend_trap)) begin
            w_nxt_pend_valid = 1'b1;
            w_nxt_pend_trap  = 1'b0;
            w_nxt_pend_addr  = w_redir_addr;
          end
        end else begin
          // Release: a live redirect outranks whatever was buffered
          w_nxt_state = S_RUN;
          if (w_redir) begin
            w_nxt_pc = w_redir_addr;
          end else if (r_pend_valid) begin
            w_nxt_pc = r_pend_addr;
          end
          w_nxt_pend_valid = 1'b0;
          w_nxt_pend_trap  = 1'b0;
          w_nxt_pend_addr  = '0;
        end
      end

      default: begin
        w_nxt_state      = S_IDLE;
        w_nxt_pc         = RESET_VECTOR;
        w_nxt_pend_valid = 1'b0;
        w_nxt_pend_trap  = 1'b0;
        w_nxt_pend_addr  = '0;
      end
    endcase

    w_nxt_if_valid = (w_nxt_state == S_RUN);
  end

  assign o_if_valid = r_if_valid;
  assign o_pc       = r_pc;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen (default XLEN=32,
// RESET_VECTOR=0). Expectations follow PC_GEN_RVC_EN if it is defined.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        i_hold;
  logic        i_jump_en;
  logic [31:0] i_jump_addr;
  logic        i_trap_en;
  logic [31:0] i_trap_addr;
  logic        i_is_c;
  logic        i_if_ready;
  logic        o_if_valid;
  logic [31:0] o_pc;

  int checks;
  int failures;

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .i_hold      (i_hold),
    .i_jump_en   (i_jump_en),
    .i_jump_addr (i_jump_addr),
    .i_trap_en   (i_trap_en),
    .i_trap_addr (i_trap_addr),
    .i_is_c      (i_is_c),
    .i_if_ready  (i_if_ready),
    .o_if_valid  (o_if_valid),
    .o_pc        (o_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    i_jump_en   = 1'b0;
    i_trap_en   = 1'b0;
    i_jump_addr = '0;
    i_trap_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_hold = 1'b0; i_is_c = 1'b0; i_if_ready = 1'b0;
    clear_redirects();
    tick(); tick();
    checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", o_pc, 32'h0); end
    checks++; if (o_if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_if_valid); end
    rst = 1'b0; i_if_ready = 1'b1;
    // First cycle out of reset is IDLE: no request yet
    checks++; if (o_if_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", o_if_valid); end
    tick();
    checks++; if (o_pc !== 32'h0 || o_if_valid !== 1'b1) begin failures++; $display("FAIL first_fetch got=%h/%b exp=00000000/1", o_pc, o_if_valid); end
    tick();
    checks++; if (o_pc !== 32'h4) begin failures++; $display("FAIL seq_4 got=%h exp=%h", o_pc, 32'h4); end
    tick();
    checks++; if (o_pc !== 32'h8) begin failures++; $display("FAIL seq_8 got=%h exp=%h", o_pc, 32'h8); end
    tick();
    checks++; if (o_pc !== 32'hC) begin failures++; $display("FAIL seq_c got=%h exp=%h", o_pc, 32'hC); end
  endtask

  task automatic test_stall();
    tick();
    checks++; if (o_pc !== 32'h10) begin failures++; $display("FAIL seq_10 got=%h exp=%h", o_pc, 32'h10); end
    i_if_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (o_pc !== 32'h10 || o_if_valid !== 1'b1) begin failures++; $display("FAIL stall_%0d got=%h/%b exp=00000010/1", i, o_pc, o_if_valid); end
    end
    i_if_ready = 1'b1;
    tick();
    checks++; if (o_pc !== 32'h14) begin failures++; $display("FAIL stall_release got=%h exp=%h", o_pc, 32'h14); end
    i_if_ready = 1'b0;
  endtask

  task automatic test_priority();
    i_trap_en = 1'b1; i_trap_addr = 32'h100;
    i_jump_en = 1'b1; i_jump_addr = 32'h200;
    tick();
    checks++; if (o_pc !== 32'h100 || o_if_valid !== 1'b1) begin failures++; $display("FAIL trap_over_jump got=%h/%b exp=00000100/1", o_pc, o_if_valid); end
    clear_redirects();
  endtask

  task automatic test_hold_pending();
    i_hold = 1'b1;
    tick();
    checks++; if (o_pc !== 32'h100 || o_if_valid !== 1'b0) begin failures++; $display("FAIL hold_enter got=%h/%b exp=00000100/0", o_pc, o_if_valid); end
    i_jump_en = 1'b1; i_jump_addr = 32'h300;
    tick();
    clear_redirects(); i_trap_en = 1'b1; i_trap_addr = 32'h80;
    tick();
    clear_redirects(); i_jump_en = 1'b1; i_jump_addr = 32'h400;
    tick();
    checks++; if (o_pc !== 32'h100 || o_if_valid !== 1'b0) begin failures++; $display("FAIL hold_frozen got=%h/%b exp=00000100/0", o_pc, o_if_valid); end
    clear_redirects(); i_hold = 1'b0;
    tick();
    checks++; if (o_pc !== 32'h80 || o_if_valid !== 1'b1) begin failures++; $display("FAIL pend_trap_kept got=%h/%b exp=00000080/1", o_pc, o_if_valid); end
  endtask

  task automatic test_pend_overwrite();
    i_hold = 1'b1; tick();
    i_jump_en = 1'b1; i_jump_addr = 32'h140; tick();
    i_jump_addr = 32'h180; tick();
    clear_redirects(); i_hold = 1'b0; tick();
    checks++; if (o_pc !== 32'h180) begin failures++; $display("FAIL jump_over_jump got=%h exp=%h", o_pc, 32'h180); end
    i_hold = 1'b1; tick();
    i_trap_en = 1'b1; i_trap_addr = 32'h1C0; tick();
    i_trap_addr = 32'h1E0; tick();
    clear_redirects(); i_hold = 1'b0; tick();
    checks++; if (o_pc !== 32'h1E0) begin failures++; $display("FAIL trap_over_trap got=%h exp=%h", o_pc, 32'h1E0); end
    i_hold = 1'b1; tick();
    i_jump_en = 1'b1; i_jump_addr = 32'h240; tick();
    clear_redirects(); i_trap_en = 1'b1; i_trap_addr = 32'h280; tick();
    clear_redirects(); i_hold = 1'b0; tick();
    checks++; if (o_pc !== 32'h280) begin failures++; $display("FAIL trap_over_jump_pend got=%h exp=%h", o_pc, 32'h280); end
  endtask

  task automatic test_release_redirect();
    i_hold = 1'b1; tick();
    i_jump_en = 1'b1; i_jump_addr = 32'h600; tick();
    i_hold = 1'b0; i_jump_addr = 32'h700; tick();
    checks++; if (o_pc !== 32'h700 || o_if_valid !== 1'b1) begin failures++; $display("FAIL release_redirect got=%h/%b exp=00000700/1", o_pc, o_if_valid); end
    clear_redirects();
    i_hold = 1'b1; tick();
    i_hold = 1'b0; tick();
    checks++; if (o_pc !== 32'h700) begin failures++; $display("FAIL pend_cleared got=%h exp=%h", o_pc, 32'h700); end
  endtask

  task automatic test_hold_rise_redirect();
    i_hold = 1'b1; i_jump_en = 1'b1; i_jump_addr = 32'h500;
    tick();
    checks++; if (o_pc !== 32'h500 || o_if_valid !== 1'b0) begin failures++; $display("FAIL hold_rise_redirect got=%h/%b exp=00000500/0", o_pc, o_if_valid); end
    clear_redirects(); i_hold = 1'b0;
    tick();
    checks++; if (o_pc !== 32'h500 || o_if_valid !== 1'b1) begin failures++; $display("FAIL hold_rise_release got=%h/%b exp=00000500/1", o_pc, o_if_valid); end
  endtask

  task automatic test_align_and_rvc();
    logic [31:0] exp_j, exp_t, exp_c, exp_n;
`ifdef PC_GEN_RVC_EN
    exp_j = 32'h36; exp_t = 32'h102; exp_c = 32'h22; exp_n = 32'h26;
`else
    exp_j = 32'h34; exp_t = 32'h100; exp_c = 32'h24; exp_n = 32'h28;
`endif
    i_jump_en = 1'b1; i_jump_addr = 32'h37; tick();
    checks++; if (o_pc !== exp_j) begin failures++; $display("FAIL align_jump got=%h exp=%h", o_pc, exp_j); end
    clear_redirects(); i_trap_en = 1'b1; i_trap_addr = 32'h103; tick();
    checks++; if (o_pc !== exp_t) begin failures++; $display("FAIL align_trap got=%h exp=%h", o_pc, exp_t); end
    clear_redirects(); i_jump_en = 1'b1; i_jump_addr = 32'h20; tick();
    clear_redirects(); i_if_ready = 1'b1; i_is_c = 1'b1; tick();
    checks++; if (o_pc !== exp_c) begin failures++; $display("FAIL inc_is_c got=%h exp=%h", o_pc, exp_c); end
    i_is_c = 1'b0; tick();
    checks++; if (o_pc !== exp_n) begin failures++; $display("FAIL inc_word got=%h exp=%h", o_pc, exp_n); end
    i_if_ready = 1'b0;
  endtask

  task automatic test_wrap();
    i_jump_en = 1'b1; i_jump_addr = 32'hFFFF_FFFC; tick();
    checks++; if (o_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_setup got=%h exp=%h", o_pc, 32'hFFFF_FFFC); end
    clear_redirects(); i_if_ready = 1'b1; tick();
    checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL wrap got=%h exp=%h", o_pc, 32'h0); end
    i_if_ready = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    i_jump_en = 1'b1; i_jump_addr = 32'h900; tick();
    clear_redirects(); i_hold = 1'b1; tick();
    i_trap_en = 1'b1; i_trap_addr = 32'h80; tick();
    clear_redirects();
    rst = 1'b1;
    #1;
    checks++; if (o_pc !== 32'h0 || o_if_valid !== 1'b0) begin failures++; $display("FAIL async_reset got=%h/%b exp=00000000/0", o_pc, o_if_valid); end
    tick();
    rst = 1'b0; i_hold = 1'b0; i_if_ready = 1'b1;
    checks++; if (o_pc !== 32'h0 || o_if_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%h/%b exp=00000000/0", o_pc, o_if_valid); end
    tick();
    checks++; if (o_pc !== 32'h0 || o_if_valid !== 1'b1) begin failures++; $display("FAIL pend_discarded got=%h/%b exp=00000000/1", o_pc, o_if_valid); end
    tick();
    checks++; if (o_pc !== 32'h4) begin failures++; $display("FAIL post_reset_seq got=%h exp=%h", o_pc, 32'h4); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stall();
    test_priority();
    test_hold_pending();
    test_pend_overwrite();
    test_release_redirect();
    test_hold_rise_redirect();
    test_align_and_rvc();
    test_wrap();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, width of all address ports and of the PC register.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 hold  input  1  pipeline stall; when 1, freeze fetch and withhold the request.
REQ-006 jump_en  input  1  branch/jump redirect request.
REQ-007 jump_addr  input  XLEN  branch/jump target.
REQ-008 trap_en  input  1  exception/interrupt redirect request.
REQ-009 trap_addr  input  XLEN  trap vector target.
REQ-010 is_c  input  1  current fetched instruction is 16-bit; used only with RVC_EN.
REQ-011 if_ready  input  1  fetch unit accepts the request this cycle.
REQ-012 if_valid  output  1  fetch request valid.
REQ-013 pc  output  XLEN  fetch address, registered.

Function
REQ-014 The block SHALL implement three states: IDLE, RUN and HOLD.
REQ-015 IDLE: entered on reset; if_valid=0; next cycle SHALL go to RUN with pc=RESET_VECTOR.
REQ-016 RUN: if_valid=1; handshake fires when if_valid && if_ready.
REQ-017 RUN without redirect or handshake: pc and if_valid SHALL hold stable.
REQ-018 RUN with handshake and no redirect: pc SHALL advance by the increment (REQ-027) on the next edge.
REQ-019 Redirect priority SHALL be trap_en > jump_en > sequential; a redirect in RUN SHALL load its target into pc on the next edge whether or not the handshake fired. This is the only case where a pending request may change.
REQ-020 hold=1 in RUN or IDLE->RUN transition SHALL enter HOLD next cycle; in HOLD, if_valid=0 and pc frozen.
REQ-021 A redirect arriving in HOLD SHALL be latched into a pending register (pend_valid, pend_trap, pend_addr).
REQ-022 A later trap SHALL overwrite a pending jump; a later jump SHALL NOT overwrite a pending trap; a later trap SHALL overwrite a pending trap; a later jump SHALL overwrite a pending jump.
REQ-023 hold falling: next cycle state=RUN and pc=pend_addr if pend_valid, else unchanged; pending cleared.
REQ-024 Redirect in the same cycle hold falls SHALL win over the pending register; the pending register SHALL be cleared.
REQ-025 A redirect in the same cycle hold rises SHALL be applied to pc immediately; the block SHALL then enter HOLD with pending clear.
REQ-026 Redirect targets SHALL have bit 0 forced to 0.
REQ-027 The increment SHALL be 4; pc addition SHALL wrap modulo 2^XLEN (pc=all-ones-minus-3 +4 -> 0).

Reset
REQ-028 rst=1 SHALL immediately set state=IDLE, pc=RESET_VECTOR, if_valid=0, pend_valid=0, pend_trap=0, pend_addr=0.
REQ-029 Reset asserted mid-HOLD or mid-handshake SHALL discard all pending redirects with no fetch issued.

Configuration
REQ-030 Macro PC_GEN_RVC_EN: when defined, increment SHALL be 2 if is_c=1 else 4, and redirect bit 1 SHALL pass through.
REQ-031 When PC_GEN_RVC_EN is undefined, is_c SHALL be ignored, increment SHALL always be 4, and redirect bits [1:0] SHALL be forced to 0.

Verification
REQ-032 Release rst, if_ready=1 for 3 cycles -> pc sequence 0x0, 0x4, 0x8, 0xC; if_valid 0 in the first cycle, then 1.
REQ-033 if_ready=0 for 4 cycles at pc=0x10 -> pc stays 0x10 and if_valid stays 1; if_ready=1 -> pc=0x14.
REQ-034 Same cycle trap_en=1 with trap_addr=0x100 and jump_en=1 with jump_addr=0x200 -> pc=0x100 next cycle.
REQ-035 hold=1, then jump to 0x300, then trap to 0x80, then jump to 0x400, then hold=0 -> pc=0x80 and if_valid=1 one cycle after release.
REQ-036 With PC_GEN_RVC_EN defined: pc=0x20, is_c=1, handshake -> 0x22; jump_addr=0x37 -> 0x36. Without the macro, jump_addr=0x37 -> 0x34.
REQ-037 pc=0xFFFF_FFFC with handshake -> 0x0; assert rst during HOLD with a pending trap -> pc=RESET_VECTOR after release.
